// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution sequencer: holds ID until forwarded operands are valid,
// evaluates the comparator flags, and issues a one-cycle PC redirect / $31 link write.
module branch_resolve_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic             opnd_ready,
    input  logic             cmp_zero,
    input  logic             cmp_nonneg,
    input  logic [31:0]      br_target,
    input  logic [31:0]      pc_plus8,
    input  logic             flush,
    output logic             stall_id,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             link_we,
    output logic [31:0]      link_data,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    localparam int unsigned          WAIT_W     = 8;
    localparam logic [WAIT_W-1:0]    WAIT_MAX   = WAIT_W'(MAX_WAIT);
    localparam logic [2:0]           BR_BEQ     = 3'd0;
    localparam logic [2:0]           BR_BNE     = 3'd1;
    localparam logic [2:0]           BR_BGEZ    = 3'd2;
    localparam logic [2:0]           BR_BLTZ    = 3'd3;
    localparam logic [2:0]           BR_BGEZALR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_RESOLVED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic              link_we_q, link_we_d;
    logic [31:0]       link_data_q, link_data_d;
    logic              err_illegal_q, err_illegal_d;
    logic              err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0]  ntaken_cnt_q, ntaken_cnt_d;

    logic              resolve_c;
    logic              taken_c;
    logic              is_link_c;
    logic              illegal_c;

    // Branch condition decode from the comparator flags
    always_comb begin
        taken_c   = 1'b0;
        is_link_c = 1'b0;
        illegal_c = 1'b0;
        case (br_type)
            BR_BEQ:     taken_c = cmp_zero;
            BR_BNE:     taken_c = ~cmp_zero;
            BR_BGEZ:    taken_c = cmp_nonneg;
            BR_BLTZ:    taken_c = ~cmp_nonneg;
            BR_BGEZALR: begin
                taken_c   = cmp_nonneg;
                is_link_c = 1'b1;
            end
            default:    illegal_c = 1'b1;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d          = state_q;
        wait_cnt_d       = wait_cnt_q;
        resolve_c        = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        link_data_d      = link_data_q;
        err_illegal_d    = err_illegal_q;
        taken_cnt_d      = taken_cnt_q;
        ntaken_cnt_d     = ntaken_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    if (opnd_ready) begin
                        resolve_c = 1'b1;
                        state_d   = ST_RESOLVED;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (opnd_ready) begin
                    resolve_c  = 1'b1;
                    state_d    = ST_RESOLVED;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_RESOLVED: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase

        // Flush cancels whatever is in flight, including a same-cycle resolve
        if (flush) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            resolve_c  = 1'b0;
        end

        redirect_valid_d = resolve_c & taken_c & ~illegal_c;
        link_we_d        = resolve_c & is_link_c;

        if (resolve_c) begin
            redirect_pc_d = br_target;
            link_data_d   = pc_plus8;
            if (illegal_c) begin
                err_illegal_d = 1'b1;
            end else if (taken_c) begin
                if (taken_cnt_q != {CNT_W{1'b1}}) begin
                    taken_cnt_d = taken_cnt_q + CNT_W'(1);
                end
            end else begin
                if (ntaken_cnt_q != {CNT_W{1'b1}}) begin
                    ntaken_cnt_d = ntaken_cnt_q + CNT_W'(1);
                end
            end
        end

        err_timeout_d = err_timeout_q | (wait_cnt_d == WAIT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            wait_cnt_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            link_we_q        <= 1'b0;
            link_data_q      <= '0;
            err_illegal_q    <= 1'b0;
            err_timeout_q    <= 1'b0;
            taken_cnt_q      <= '0;
            ntaken_cnt_q     <= '0;
        end else begin
            state_q          <= state_d;
            wait_cnt_q       <= wait_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            link_we_q        <= link_we_d;
            link_data_q      <= link_data_d;
            err_illegal_q    <= err_illegal_d;
            err_timeout_q    <= err_timeout_d;
            taken_cnt_q      <= taken_cnt_d;
            ntaken_cnt_q     <= ntaken_cnt_d;
        end
    end

    // A branch sitting in ID during RESOLVED is held until the FSM is back in IDLE
    assign stall_id = br_valid & ((state_q == ST_RESOLVED) |
                                  (~opnd_ready & ((state_q == ST_IDLE) | (state_q == ST_WAIT))));

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign link_we        = link_we_q;
    assign link_data      = link_data_q;
    assign err_illegal    = err_illegal_q;
    assign err_timeout    = err_timeout_q;
    assign taken_cnt      = taken_cnt_q;
    assign ntaken_cnt     = ntaken_cnt_q;

endmodule
